pixel_merger: RTL

//  Merges pixel streams from up to NUM_CORES parallel ray-trace cores into one raster-ordered video stream.

---
 rtl/pixel_merger.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_merger.sv
// rtl/pixel_merger.sv - merges per-core pixel FIFOs into one raster-ordered AXI4-Stream
module pixel_merger #(
  parameter int NUM_CORES  = 4,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 13
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_CORES*3*COLOR_W-1:0] core_pixel,
  input  logic [NUM_CORES-1:0]           core_valid,
  output logic [NUM_CORES-1:0]           core_ready,
  input  logic [$clog2(NUM_CORES):0]     extra_cores,
  input  logic [DIM_W-1:0]               image_width,
  input  logic [DIM_W-1:0]               image_height,
  output logic [3*COLOR_W-1:0]           out_tdata,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic                           out_tuser,
  output logic                           out_tlast,
  output logic                           frame_done,
  output logic                           drop_err
);
  localparam int PW = 3*COLOR_W;
  localparam int LW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;

  logic [PW-1:0]    mem [NUM_CORES][FIFO_DEPTH];
  logic [AW:0]      wr_ptr [NUM_CORES];
  logic [AW:0]      rd_ptr [NUM_CORES];
  logic [NUM_CORES-1:0] full, empty, push;

  logic [LW-1:0]    ptr, ptr_adv;
  logic [DIM_W-1:0] x, y;
  logic             out_eof;
  logic             live_q;

  logic [LW-1:0]    cfg_ext, ext_live, ext_eff;
  logic [DIM_W-1:0] cfg_w, cfg_h, w_live, h_live, w_eff, h_eff;
  logic             cfg_live, end_acc, load, last_x, last_y;
  logic [AW:0]      rd_sel;
  logic [PW-1:0]    head;

  // Clamp/normalise the live configuration inputs.
  always_comb begin
    ext_live = LW'(extra_cores);
    if (int'(extra_cores) >= NUM_CORES) ext_live = LW'(NUM_CORES-1);
    w_live = (image_width  == '0) ? DIM_W'(1) : image_width;
    h_live = (image_height == '0) ? DIM_W'(1) : image_height;
  end

  // Live config applies between frames; a running frame uses the latched copy.
  always_comb begin
    ext_eff = cfg_live ? ext_live : cfg_ext;
    w_eff   = cfg_live ? w_live   : cfg_w;
    h_eff   = cfg_live ? h_live   : cfg_h;
  end

  // FIFO flags, lane handshake and the head entry of the lane under ptr.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      empty[i]      = (wr_ptr[i] == rd_ptr[i]);
      full[i]       = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                      (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      core_ready[i] = live_q && (LW'(i) <= ext_eff) && !full[i];
      push[i]       = core_valid[i] && core_ready[i];
    end
    rd_sel  = rd_ptr[ptr];
    head    = mem[ptr][rd_sel[AW-1:0]];
    load    = !empty[ptr] && (!out_tvalid || out_tready);
    last_x  = (x == w_eff - DIM_W'(1));
    last_y  = (y == h_eff - DIM_W'(1));
    ptr_adv = (ptr == ext_eff) ? '0 : ptr + LW'(1);
  end

  // FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: a load in the frame-boundary window starts (or continues) streaming.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = STREAM;
      STREAM:  if (end_acc && !load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: config is open while idle or in the cycle the frame's last beat leaves.
  always_comb begin
    end_acc  = out_tvalid && out_tready && out_eof;
    cfg_live = (state == IDLE) || end_acc;
  end

  // Latch the frame configuration while it is open.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_ext <= '0;
      cfg_w   <= DIM_W'(1);
      cfg_h   <= DIM_W'(1);
    end else if (cfg_live) begin
      cfg_ext <= ext_live;
      cfg_w   <= w_live;
      cfg_h   <= h_live;
    end
  end

  // FIFO storage; contents need no reset since pointers guard every read.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_CORES; i++)
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= core_pixel[i*PW +: PW];
  end

  // FIFO pointers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
        if (load && ptr == LW'(i)) rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
      end
    end
  end

  // Output register with raster counters and lane pointer advancing on each load.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tuser  <= 1'b0;
      out_tlast  <= 1'b0;
      out_eof    <= 1'b0;
      x          <= '0;
      y          <= '0;
      ptr        <= '0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tdata  <= head;
      out_tuser  <= (x == '0) && (y == '0);
      out_tlast  <= last_x;
      out_eof    <= last_x && last_y;
      if (last_x) begin
        x <= '0;
        if (last_y) begin
          y   <= '0;
          ptr <= '0;
        end else begin
          y   <= y + DIM_W'(1);
          ptr <= ptr_adv;
        end
      end else begin
        x   <= x + DIM_W'(1);
        ptr <= ptr_adv;
      end
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  // Ready enable after reset, frame-done pulse and sticky drop flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      live_q     <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      frame_done <= end_acc;
      if (|(core_valid & ~core_ready)) drop_err <= 1'b1;
    end
  end

endmodule
